// File: rtl/piradip_axis_peak_meter.sv
// rtl/piradip_axis_peak_meter.sv - AXI4-Stream pass-through with per-frame peak/clip statistics (optional clip counting: PIRADIP_PEAK_METER_CLIP_COUNT_EN)
module piradip_axis_peak_meter #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int N_SAMPLES        = 8,
  parameter int CLIP_COUNT_WIDTH = 16
) (
  input  logic                              stream_clk,
  input  logic                              stream_rst,
  input  logic [N_SAMPLES*SAMPLE_WIDTH-1:0] s_tdata,
  input  logic                              s_tvalid,
  output logic                              s_tready,
  input  logic                              s_tlast,
  output logic [N_SAMPLES*SAMPLE_WIDTH-1:0] m_tdata,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              m_tlast,
  output logic                              stat_valid,
  output logic [SAMPLE_WIDTH-1:0]           stat_peak,
  output logic [CLIP_COUNT_WIDTH-1:0]       stat_clips,
  output logic [31:0]                       stat_frames
);

  localparam int DW = N_SAMPLES * SAMPLE_WIDTH;

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t            state, state_next;
  logic              accept;
  logic              load_main;
  logic              main_valid, skid_valid, ready_q;
  logic [DW-1:0]     main_data, skid_data;
  logic              main_last, skid_last;
  logic [SAMPLE_WIDTH-1:0] run_peak, beat_peak, frame_peak;

  assign accept    = s_tvalid & ready_q;
  assign load_main = m_tready | ~main_valid;
  assign s_tready  = ready_q;
  assign m_tvalid  = main_valid;
  assign m_tdata   = main_data;
  assign m_tlast   = main_last;

  // Skid buffer: main register feeds the output, skid register catches a beat while the output stalls
  always_ff @(posedge stream_clk or posedge stream_rst) begin
    if (stream_rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_last  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      ready_q    <= 1'b0;
    end else if (load_main) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_last  <= skid_last;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) begin
          main_data <= s_tdata;
          main_last <= s_tlast;
        end
      end
      ready_q <= 1'b1;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= s_tdata;
      skid_last  <= s_tlast;
      ready_q    <= 1'b0;
    end else begin
      ready_q <= ~skid_valid;
    end
  end

  // Per-beat lane magnitudes; the most negative sample maps to 2^(W-1) without wrapping
  always_comb begin
    logic [SAMPLE_WIDTH-1:0] lane;
    logic [SAMPLE_WIDTH-1:0] mag;
    beat_peak = '0;
    lane      = '0;
    mag       = '0;
    for (int j = 0; j < N_SAMPLES; j++) begin
      lane = s_tdata[j*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      mag  = lane[SAMPLE_WIDTH-1] ? (~lane + SAMPLE_WIDTH'(1)) : lane;
      if (mag > beat_peak) beat_peak = mag;
    end
  end

  // The running peak only counts once a frame has started accumulating
  always_comb begin
    logic [SAMPLE_WIDTH-1:0] base_peak;
    base_peak  = (state == S_ACCUM) ? run_peak : '0;
    frame_peak = (beat_peak > base_peak) ? beat_peak : base_peak;
  end

  // Frame-state register
  always_ff @(posedge stream_clk or posedge stream_rst) begin
    if (stream_rst) state <= S_IDLE;
    else            state <= state_next;
  end

  // Frame-state transitions on accepted beats
  always_comb begin
    state_next = state;
    if (accept) state_next = s_tlast ? S_IDLE : S_ACCUM;
  end

  // Peak accumulation and frame-end statistics
  always_ff @(posedge stream_clk or posedge stream_rst) begin
    if (stream_rst) begin
      run_peak    <= '0;
      stat_valid  <= 1'b0;
      stat_peak   <= '0;
      stat_frames <= '0;
    end else begin
      stat_valid <= accept & s_tlast;
      if (accept) begin
        if (s_tlast) begin
          stat_peak   <= frame_peak;
          stat_frames <= stat_frames + 32'd1;
          run_peak    <= '0;
        end else begin
          run_peak <= frame_peak;
        end
      end
    end
  end

`ifdef PIRADIP_PEAK_METER_CLIP_COUNT_EN
  localparam int BCW = $clog2(N_SAMPLES + 1);

  logic [BCW-1:0]              beat_clips;
  logic [CLIP_COUNT_WIDTH-1:0] run_clips, frame_clips, stat_clips_q;

  assign stat_clips = stat_clips_q;

  // Count lanes sitting at either full-scale rail
  always_comb begin
    logic [SAMPLE_WIDTH-1:0] lane;
    beat_clips = '0;
    lane       = '0;
    for (int j = 0; j < N_SAMPLES; j++) begin
      lane = s_tdata[j*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      if (lane == {1'b0, {(SAMPLE_WIDTH-1){1'b1}}} || lane == {1'b1, {(SAMPLE_WIDTH-1){1'b0}}})
        beat_clips = beat_clips + BCW'(1);
    end
  end

  // Saturating add of this beat's clips onto the frame total
  always_comb begin
    logic [CLIP_COUNT_WIDTH-1:0] base_clips;
    logic [CLIP_COUNT_WIDTH:0]   clip_sum;
    base_clips  = (state == S_ACCUM) ? run_clips : '0;
    clip_sum    = {1'b0, base_clips} + (CLIP_COUNT_WIDTH+1)'(beat_clips);
    frame_clips = clip_sum[CLIP_COUNT_WIDTH] ? '1 : clip_sum[CLIP_COUNT_WIDTH-1:0];
  end

  // Clip accumulation and frame-end clip statistic
  always_ff @(posedge stream_clk or posedge stream_rst) begin
    if (stream_rst) begin
      run_clips    <= '0;
      stat_clips_q <= '0;
    end else if (accept) begin
      if (s_tlast) begin
        stat_clips_q <= frame_clips;
        run_clips    <= '0;
      end else begin
        run_clips <= frame_clips;
      end
    end
  end
`else
  assign stat_clips = '0;
`endif

endmodule

// File: tb/tb_piradip_axis_peak_meter.sv
// tb/tb_piradip_axis_peak_meter.sv - self-checking bench for piradip_axis_peak_meter
module tb_piradip_axis_peak_meter;

  localparam int W   = 16;
  localparam int N   = 8;
  localparam int CCW = 16;
  localparam int DW  = W * N;

  logic            stream_clk = 1'b0;
  logic            stream_rst;
  logic [DW-1:0]   s_tdata;
  logic            s_tvalid;
  logic            s_tready;
  logic            s_tlast;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic            stat_valid;
  logic [W-1:0]    stat_peak;
  logic [CCW-1:0]  stat_clips;
  logic [31:0]     stat_frames;

  piradip_axis_peak_meter #(.SAMPLE_WIDTH(W), .N_SAMPLES(N), .CLIP_COUNT_WIDTH(CCW)) dut (
    .stream_clk(stream_clk), .stream_rst(stream_rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .stat_valid(stat_valid), .stat_peak(stat_peak), .stat_clips(stat_clips), .stat_frames(stat_frames)
  );

  always #5 stream_clk = ~stream_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lane_of(input logic [DW-1:0] d, input int j);
    logic signed [W-1:0] s;
    s = d[j*W +: W];
    return int'(s);
  endfunction

  // Reference model: expected output beats and per-frame statistics from plain arithmetic
  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  beat_t exp_q[$];
  int  run_peak, run_clips;
  int  nxt_peak, nxt_clips, nxt_frames;
  int  vis_peak, vis_clips, vis_frames;
  bit  pending;
  bit  since_rst;
  int  cyc = 0;
  int  pulse_peak[$];
  int  pulse_cyc[$];
  bit  rand_ready = 1'b0;

  always @(posedge stream_clk) cyc <= cyc + 1;

  always @(negedge stream_clk) begin
    bit    acc, del;
    int    x, mag;
    beat_t b;
    if (stream_rst) begin
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_stat_valid", stat_valid, 0);
      chk("rst_stat_peak", stat_peak, 0);
      chk("rst_stat_clips", stat_clips, 0);
      chk("rst_stat_frames", stat_frames, 0);
      exp_q.delete();
      run_peak = 0; run_clips = 0; pending = 0;
      vis_peak = 0; vis_clips = 0; vis_frames = 0;
      since_rst = 0;
    end else begin
      acc = (s_tvalid === 1'b1) && (s_tready === 1'b1);
      del = (m_tvalid === 1'b1) && (m_tready === 1'b1);
      if (pending) begin
        vis_peak = nxt_peak; vis_clips = nxt_clips; vis_frames = nxt_frames;
      end
      chk("stat_valid", stat_valid, pending);
      if (stat_valid === 1'b1) begin
        pulse_peak.push_back(int'(stat_peak));
        pulse_cyc.push_back(cyc);
      end
      chk("stat_peak", stat_peak, vis_peak);
      chk("stat_clips", stat_clips, vis_clips);
      chk("stat_frames", stat_frames, vis_frames);
      if (!since_rst) begin
        chk("s_tready_after_rst", s_tready, 0);
        since_rst = 1;
      end else begin
        chk("s_tready", s_tready, exp_q.size() <= 1);
      end
      chk("m_tvalid", m_tvalid, exp_q.size() > 0);
      if (del && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("m_tdata", m_tdata, b.d);
        chk("m_tlast", m_tlast, b.l);
      end
      pending = 0;
      if (acc) begin
        b.d = s_tdata; b.l = s_tlast;
        exp_q.push_back(b);
        for (int j = 0; j < N; j++) begin
          x   = lane_of(s_tdata, j);
          mag = (x < 0) ? -x : x;
          if (mag > run_peak) run_peak = mag;
`ifdef PIRADIP_PEAK_METER_CLIP_COUNT_EN
          if (x == 32767 || x == -32768) run_clips = (run_clips >= 65535) ? 65535 : run_clips + 1;
`endif
        end
        if (s_tlast === 1'b1) begin
          nxt_peak = run_peak; nxt_clips = run_clips; nxt_frames = vis_frames + 1;
          pending = 1;
          run_peak = 0; run_clips = 0;
        end
      end
    end
  end

  // Output back-pressure: random when enabled, otherwise always ready
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge stream_clk); #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [DW-1:0] d, input logic l);
    int t;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    t = 0;
    @(negedge stream_clk);
    while (s_tready !== 1'b1 && t < 1000) begin
      @(negedge stream_clk);
      t++;
    end
    if (t >= 1000) begin
      total++; bad++;
      $error("FAIL send_timeout observed=%0d expected<1000", t);
    end
    @(posedge stream_clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge stream_clk);
    #1;
  endtask

  task automatic ramp_stream();
    logic [DW-1:0] d;
    for (int i = 0; i < 100; i++) begin
      for (int j = 0; j < N; j++) d[j*W +: W] = W'(i*8 + j);
      send(d, (i % 8 == 7) || (i == 99));
    end
  endtask

  int            ref_peaks[$];
  logic [DW-1:0] d;
  int            exp_clip2, exp_clip_sat;

  initial begin
`ifdef PIRADIP_PEAK_METER_CLIP_COUNT_EN
    exp_clip2 = 2; exp_clip_sat = 65535;
`else
    exp_clip2 = 0; exp_clip_sat = 0;
`endif
    stream_rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    idle(3);
    stream_rst = 1'b0;
    idle(2);

    // Ramp stream at full throughput
    pulse_peak.delete(); pulse_cyc.delete();
    ramp_stream();
    idle(5);
    chk("ramp_pulses", pulse_peak.size(), 13);
    if (pulse_peak.size() == 13) begin
      chk("ramp_first_peak", pulse_peak[0], 63);
      chk("ramp_last_peak", pulse_peak[12], 799);
    end
    chk("ramp_frames", stat_frames, 13);
    chk("ramp_drained", exp_q.size(), 0);
    ref_peaks = pulse_peak;

    // Same ramp under random back-pressure
    pulse_peak.delete(); pulse_cyc.delete();
    rand_ready = 1'b1;
    ramp_stream();
    rand_ready = 1'b0;
    idle(10);
    chk("bp_pulses", pulse_peak.size(), ref_peaks.size());
    for (int k = 0; k < pulse_peak.size() && k < ref_peaks.size(); k++)
      chk("bp_peak", pulse_peak[k], ref_peaks[k]);
    chk("bp_frames", stat_frames, 26);
    chk("bp_drained", exp_q.size(), 0);

    // Full-scale lanes
    pulse_peak.delete(); pulse_cyc.delete();
    d = '0;
    d[0 +: W] = 16'h8000; d[W +: W] = 16'h7fff;
    for (int j = 2; j < N; j++) d[j*W +: W] = 16'd5;
    send(d, 1'b0);
    for (int j = 0; j < N; j++) d[j*W +: W] = W'(j + 1);
    send(d, 1'b1);
    idle(3);
    chk("fs_peak", stat_peak, 32768);
    chk("fs_clips", stat_clips, exp_clip2);

    // Random data, random gaps, random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      for (int j = 0; j < N; j++) begin
        case ($urandom_range(0, 5))
          0:       d[j*W +: W] = 16'h7fff;
          1:       d[j*W +: W] = 16'h8000;
          default: d[j*W +: W] = W'($urandom);
        endcase
      end
      send(d, ($urandom_range(0, 4) == 0) || (i == 199));
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    rand_ready = 1'b0;
    idle(10);
    chk("rand_drained", exp_q.size(), 0);

    // Back-to-back single-beat frames
    pulse_peak.delete(); pulse_cyc.delete();
    d = '0; d[0 +: W] = -16'sd3;
    send(d, 1'b1);
    d = '0; d[3*W +: W] = 16'd9;
    send(d, 1'b1);
    d = '0; d[7*W +: W] = -16'sd1;
    send(d, 1'b1);
    idle(3);
    chk("b2b_pulses", pulse_peak.size(), 3);
    if (pulse_peak.size() == 3) begin
      chk("b2b_peak0", pulse_peak[0], 3);
      chk("b2b_peak1", pulse_peak[1], 9);
      chk("b2b_peak2", pulse_peak[2], 1);
      chk("b2b_consec1", pulse_cyc[1], pulse_cyc[0] + 1);
      chk("b2b_consec2", pulse_cyc[2], pulse_cyc[1] + 1);
    end

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < N; j++) d[j*W +: W] = W'(1000 + i);
      send(d, 1'b0);
    end
    stream_rst = 1'b1;
    idle(3);
    stream_rst = 1'b0;
    idle(2);
    pulse_peak.delete(); pulse_cyc.delete();
    d = '0; d[2*W +: W] = -16'sd4; d[5*W +: W] = 16'd2;
    send(d, 1'b1);
    idle(3);
    chk("rst_pulses", pulse_peak.size(), 1);
    chk("rst_peak", stat_peak, 4);
    chk("rst_frames", stat_frames, 1);
    chk("rst_clips", stat_clips, 0);

    // Long full-scale frame saturates the clip counter
    d = '0;
    for (int j = 0; j < N; j++) d[j*W +: W] = 16'h7fff;
    for (int i = 0; i < 8750; i++) send(d, i == 8749);
    idle(3);
    chk("sat_clips", stat_clips, exp_clip_sat);
    chk("sat_peak", stat_peak, 32767);
    chk("sat_frames", stat_frames, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
